// File: rtl/collatz_ui_ctrl.sv
// Pushbutton/switch front-end for the Collatz range engine.
// Debounces keys, launches runs, and browses result offsets with auto-repeat.
module collatz_ui_ctrl #(
  parameter int SW_W          = 10,
  parameter int START_W       = 32,
  parameter int N_W           = 8,
  parameter int N_MAX         = 255,
  parameter int DEBOUNCE      = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int TIMEOUT       = 2**24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         key_n,
  input  logic [SW_W-1:0]    sw,
  input  logic               done,
  output logic               go,
  output logic [START_W-1:0] start,
  output logic [N_W-1:0]     n,
  output logic [START_W-1:0] disp_val,
  output logic               valid,
  output logic               busy,
  output logic               timeout
);

  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BROWSE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [3:0]    sync1, sync2;
  logic [3:0]    key_dn;
  logic [3:0]    press;
  logic [DW-1:0] db_cnt [4];

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_first;
  logic [1:0]    step;

  logic               go_d;
  logic [START_W-1:0] start_d;
  logic [N_W-1:0]     n_d;
  logic               timeout_d;
  logic [TW-1:0]      wcnt, wcnt_d;
  logic               launch;

  // key_dn is the debounced level, 1 = pressed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= '1;
      sync2  <= '1;
      key_dn <= '0;
      press  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (~sync2[i] == key_dn[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
          db_cnt[i] <= '0;
          key_dn[i] <= ~sync2[i];
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // step[0] belongs to KEY2 (down), step[1] to KEY3 (up)
  always_comb begin
    step = '0;
    for (int j = 0; j < 2; j++) begin
      step[j] = press[j+2] |
                (key_dn[j+2] &
                 (rep_cnt[j] == (rep_first[j] ?
                                 RW'(REPEAT_DELAY - 1) :
                                 RW'(REPEAT_PERIOD - 1))));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rep_first <= '1;
      for (int j = 0; j < 2; j++) rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (press[j+2] || !key_dn[j+2]) begin
          rep_cnt[j]   <= '0;
          rep_first[j] <= 1'b1;
        end else if (step[j]) begin
          rep_cnt[j]   <= '0;
          rep_first[j] <= 1'b0;
        end else begin
          rep_cnt[j] <= rep_cnt[j] + 1'b1;
        end
      end
    end
  end

  assign launch = press[0] & (state != RUN);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    go_d      = 1'b0;
    start_d   = start;
    n_d       = n;
    timeout_d = timeout;
    wcnt_d    = wcnt;
    unique case (state)
      IDLE: state_d = IDLE;
      RUN: begin
        // the go cycle itself never accepts done
        if (done && !go) begin
          state_d = BROWSE;
        end else if (wcnt == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      BROWSE: begin
        if (press[1]) begin
          n_d = '0;
        end else if (step == 2'b10) begin
          if (n != N_W'(N_MAX)) n_d = n + 1'b1;
        end else if (step == 2'b01) begin
          if (n != '0) n_d = n - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d   = RUN;
      go_d      = 1'b1;
      start_d   = START_W'(sw);
      n_d       = '0;
      timeout_d = 1'b0;
      wcnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      go       <= 1'b0;
      start    <= '0;
      n        <= '0;
      timeout  <= 1'b0;
      wcnt     <= '0;
      disp_val <= '0;
    end else begin
      go       <= go_d;
      start    <= start_d;
      n        <= n_d;
      timeout  <= timeout_d;
      wcnt     <= wcnt_d;
      disp_val <= start + START_W'(n);
    end
  end

  assign valid = (state == BROWSE);
  assign busy  = (state == RUN);

endmodule

// File: tb/tb_collatz_ui_ctrl.sv
// Bench for collatz_ui_ctrl: directed vector table plus
// randomized key/done traffic against a behavioural model.
module tb_collatz_ui_ctrl;

  localparam int SW_W  = 32;
  localparam int NMAX  = 255;
  localparam int DEB   = 4;
  localparam int RD    = 16;
  localparam int RP    = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic [31:0] sw = '0;
  logic        done = 1'b0;
  logic        go, valid, busy, timeout;
  logic [31:0] start, disp_val;
  logic [7:0]  n;

  collatz_ui_ctrl #(
    .SW_W(SW_W), .START_W(32), .N_W(8), .N_MAX(NMAX),
    .DEBOUNCE(DEB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n),
    .sw(sw), .done(done), .go(go), .start(start),
    .n(n), .disp_val(disp_val), .valid(valid),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int gos = 0;
  int mfail_prints = 0;

  // behavioural reference model
  typedef enum {M_IDLE, M_RUN, M_BROWSE} mst_t;
  mst_t           m_st;
  bit             m_go, m_to;
  logic [31:0]    m_start, m_disp;
  int             m_n, m_rcyc;
  bit [3:0]       m_s1, m_s2, m_db, m_press;
  logic [DEB-1:0] m_win [4];
  int             m_wlen [4];
  int             m_hage [4];

  task automatic m_reset();
    m_st = M_IDLE; m_go = 0; m_to = 0;
    m_start = '0; m_disp = '0; m_n = 0; m_rcyc = 0;
    m_s1 = '1; m_s2 = '1; m_db = '0; m_press = '0;
    for (int k = 0; k < 4; k++) begin
      m_win[k] = '0; m_wlen[k] = 0; m_hage[k] = 0;
    end
  endtask

  function automatic bit m_step(int k);
    int h;
    h = m_hage[k];
    return m_press[k] ||
           (m_db[k] && (h == RD || (h > RD && (h - RD) % RP == 0)));
  endfunction

  task automatic model_edge();
    mst_t        os;
    logic [31:0] nd;
    int          nn;
    bit          ngo, up, dn;
    bit [3:0]    np;
    if (!reset_n) begin
      m_reset();
      return;
    end
    os = m_st;
    nd = m_start + 32'(m_n);
    up = m_step(3);
    dn = m_step(2);
    ngo = 0;
    nn = m_n;
    case (os)
      M_RUN: begin
        if (done && !m_go) m_st = M_BROWSE;
        else if (m_rcyc == TMO) begin m_to = 1; m_st = M_IDLE; end
        else m_rcyc++;
      end
      M_BROWSE: begin
        if (m_press[1]) nn = 0;
        else if (up && !dn) nn = (m_n < NMAX) ? m_n + 1 : NMAX;
        else if (dn && !up) nn = (m_n > 0) ? m_n - 1 : 0;
      end
      default: ;
    endcase
    if (m_press[0] && os != M_RUN) begin
      m_st = M_RUN; ngo = 1; m_start = sw;
      nn = 0; m_to = 0; m_rcyc = 1;
    end
    m_go = ngo;
    m_n = nn;
    m_disp = nd;
    np = '0;
    for (int k = 0; k < 4; k++) begin
      bit syn;
      syn = ~m_s2[k];
      if (m_press[k]) m_hage[k] = 1;
      else if (m_db[k]) m_hage[k]++;
      else m_hage[k] = 0;
      m_win[k] = {m_win[k][DEB-2:0], syn};
      if (m_wlen[k] < DEB) m_wlen[k]++;
      if (m_wlen[k] == DEB && m_win[k] == {DEB{~m_db[k]}}) begin
        m_db[k] = syn;
        np[k] = syn;
      end
    end
    m_press = np;
    m_s2 = m_s1;
    m_s1 = key_n;
  endtask

  task automatic cmp_model();
    bit bad;
    bad = (go !== m_go) || (busy !== (m_st == M_RUN)) ||
          (valid !== (m_st == M_BROWSE)) || (timeout !== m_to) ||
          (n !== 8'(m_n)) || (start !== m_start) || (disp_val !== m_disp);
    total_cnt++;
    if (bad) begin
      if (mfail_prints < 20)
        $display("FAIL model @%0t: got go=%b busy=%b valid=%b to=%b n=%0d start=%h disp=%h want go=%b busy=%b valid=%b to=%b n=%0d start=%h disp=%h",
                 $time, go, busy, valid, timeout, n, start, disp_val,
                 m_go, m_st == M_RUN, m_st == M_BROWSE, m_to, m_n,
                 m_start, m_disp);
      mfail_prints++;
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic run1();
    model_edge();
    @(negedge clk);
    if (go) gos++;
    cmp_model();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  typedef struct {
    logic [3:0]  k;
    logic        d;
    logic [31:0] s;
    int          c;
    int          g;
    logic        b, v, t;
    int          nn;
    logic [31:0] st, dp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [3:0] k, input logic d,
                     input logic [31:0] s, input int c, input int g,
                     input logic b, input logic v, input logic t,
                     input int nn, input logic [31:0] st,
                     input logic [31:0] dp);
    vec_t r;
    r.k = k; r.d = d; r.s = s; r.c = c; r.g = g;
    r.b = b; r.v = v; r.t = t; r.nn = nn; r.st = st; r.dp = dp;
    vt.push_back(r);
  endtask

  int rem [4];

  initial begin
    // go press, exact latency, run then done
    add(4'hE, 0, 27, 6, 0, 0, 0, 0, 0, 0, 0);
    add(4'hE, 0, 27, 1, 1, 1, 0, 0, 0, 27, 0);
    add(4'hE, 0, 27, 3, 0, 1, 0, 0, 0, 27, 27);
    add(4'hF, 0, 27, 9, 0, 1, 0, 0, 0, 27, 27);
    add(4'hF, 1, 27, 1, 0, 0, 1, 0, 0, 27, 27);
    add(4'hF, 0, 27, 10, 0, 0, 1, 0, 0, 27, 27);
    // bouncing go key
    add(4'hE, 0, 100, 2, 0, 0, 1, 0, 0, 27, 27);
    add(4'hF, 0, 100, 2, 0, 0, 1, 0, 0, 27, 27);
    add(4'hE, 0, 100, 6, 0, 0, 1, 0, 0, 27, 27);
    add(4'hE, 0, 100, 1, 1, 1, 0, 0, 0, 100, 27);
    add(4'hF, 0, 5, 8, 0, 1, 0, 0, 0, 100, 100);
    add(4'hF, 1, 5, 1, 0, 0, 1, 0, 0, 100, 100);
    // KEY3 auto-repeat
    add(4'h7, 0, 5, 7, 0, 0, 1, 0, 1, 100, 100);
    add(4'h7, 0, 5, 15, 0, 0, 1, 0, 1, 100, 101);
    add(4'h7, 0, 5, 1, 0, 0, 1, 0, 2, 100, 101);
    add(4'h7, 0, 5, 17, 0, 0, 1, 0, 6, 100, 106);
    add(4'hF, 0, 5, 10, 0, 0, 1, 0, 7, 100, 107);
    // KEY1 clear, KEY2 at zero
    add(4'hD, 0, 5, 8, 0, 0, 1, 0, 0, 100, 100);
    add(4'hF, 0, 5, 8, 0, 0, 1, 0, 0, 100, 100);
    add(4'hB, 0, 5, 8, 0, 0, 1, 0, 0, 100, 100);
    add(4'hF, 0, 5, 8, 0, 0, 1, 0, 0, 100, 100);
    // saturation at N_MAX
    add(4'h7, 0, 5, 1200, 0, 0, 1, 0, 255, 100, 355);
    add(4'hF, 0, 5, 8, 0, 0, 1, 0, 255, 100, 355);
    add(4'hB, 0, 5, 8, 0, 0, 1, 0, 254, 100, 354);
    add(4'hF, 0, 5, 8, 0, 0, 1, 0, 254, 100, 354);
    add(4'h7, 0, 5, 100, 0, 0, 1, 0, 255, 100, 355);
    add(4'hF, 0, 5, 8, 0, 0, 1, 0, 255, 100, 355);
    // display wrap
    add(4'hE, 0, 32'hFFFFFFFF, 10, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    add(4'hF, 0, 0, 5, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    add(4'hF, 1, 0, 1, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    add(4'h7, 0, 0, 8, 0, 0, 1, 0, 1, 32'hFFFFFFFF, 0);
    add(4'hF, 0, 0, 8, 0, 0, 1, 0, 1, 32'hFFFFFFFF, 0);
    // timeout and its clearing
    add(4'hE, 0, 3, 10, 1, 1, 0, 0, 0, 3, 3);
    add(4'hF, 0, 3, 60, 0, 1, 0, 0, 0, 3, 3);
    add(4'hF, 0, 3, 1, 0, 0, 0, 1, 0, 3, 3);
    add(4'hF, 1, 3, 3, 0, 0, 0, 1, 0, 3, 3);
    add(4'hE, 0, 9, 10, 1, 1, 0, 0, 0, 9, 9);
    add(4'hF, 0, 9, 5, 0, 1, 0, 0, 0, 9, 9);
    add(4'hF, 1, 9, 1, 0, 0, 1, 0, 0, 9, 9);
    // KEY2+KEY3 together
    add(4'h7, 0, 9, 8, 0, 0, 1, 0, 1, 9, 10);
    add(4'hF, 0, 9, 8, 0, 0, 1, 0, 1, 9, 10);
    add(4'h3, 0, 9, 40, 0, 0, 1, 0, 1, 9, 10);
    add(4'hF, 0, 9, 8, 0, 0, 1, 0, 1, 9, 10);
    // go beats clear, clear beats step
    add(4'hC, 0, 7, 10, 1, 1, 0, 0, 0, 7, 7);
    add(4'hF, 0, 7, 5, 0, 1, 0, 0, 0, 7, 7);
    add(4'hF, 1, 7, 1, 0, 0, 1, 0, 0, 7, 7);
    add(4'h7, 0, 7, 8, 0, 0, 1, 0, 1, 7, 8);
    add(4'hF, 0, 7, 8, 0, 0, 1, 0, 1, 7, 8);
    add(4'h5, 0, 7, 8, 0, 0, 1, 0, 0, 7, 7);
    add(4'hF, 0, 7, 8, 0, 0, 1, 0, 0, 7, 7);

    // reset state
    reset_n = 1'b0;
    run1();
    run1();
    chk("rst_go", 32'(go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_n", 32'(n), 0);
    chk("rst_start", start, 0);
    chk("rst_disp", disp_val, 0);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      key_n = vt[i].k;
      done = vt[i].d;
      sw = vt[i].s;
      gos = 0;
      repeat (vt[i].c) run1();
      chk($sformatf("v%0d_gos", i), 32'(gos), 32'(vt[i].g));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vt[i].v));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vt[i].t));
      chk($sformatf("v%0d_n", i), 32'(n), 32'(vt[i].nn));
      chk($sformatf("v%0d_start", i), start, vt[i].st);
      chk($sformatf("v%0d_disp", i), disp_val, vt[i].dp);
    end

    // reset in the middle of a run
    done = 1'b0;
    sw = 42;
    key_n = 4'hE;
    repeat (10) run1();
    key_n = 4'hF;
    repeat (5) run1();
    chk("mid_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    run1();
    chk("mid_go", 32'(go), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_valid", 32'(valid), 0);
    chk("mid_timeout", 32'(timeout), 0);
    chk("mid_n", 32'(n), 0);
    chk("mid_start", start, 0);
    chk("mid_disp", disp_val, 0);
    reset_n = 1'b1;
    gos = 0;
    repeat (30) run1();
    chk("mid_no_repulse", 32'(gos), 0);
    chk("mid_idle", 32'(busy | valid), 0);

    // randomized traffic
    for (int k = 0; k < 4; k++) rem[k] = $urandom_range(1, 30);
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          rem[k] = ($urandom_range(0, 3) == 0) ?
                   $urandom_range(1, 3) : $urandom_range(5, 60);
        end else begin
          rem[k]--;
        end
      end
      done = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 49) == 0) sw = $urandom;
      reset_n = ($urandom_range(0, 799) != 0);
      run1();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
